// File: rtl/clawgame_pkg.sv
// clawgame_pkg -- shared types and constants for the score event path.
//   PEND_W      : width of the pending-event counter
//   MAX_PENDING : highest pending count held before new events are dropped
//   hs_state_e  : handshake FSM states toward the processor wrapper
package clawgame_pkg;
  localparam int PEND_W      = 3;
  localparam int MAX_PENDING = 7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DROP = 2'd2
  } hs_state_e;
endpackage

// File: rtl/score_event_sync_if.sv
// score_event_sync_if -- bundles the score contact, game gating and the
// request/acknowledge handshake with the processor wrapper.
//   master : side that drives score_raw, game_active and the acknowledge
//   slave  : score event block (request, pending count, drop flag)
interface score_event_sync_if;
  import clawgame_pkg::*;

  logic              score_raw;
  logic              game_active;
  logic              finished_incrementing_score;
  logic              need_to_increment_score;
  logic [PEND_W-1:0] pending_count;
  logic              dropped;

  modport master (
    output score_raw, game_active, finished_incrementing_score,
    input  need_to_increment_score, pending_count, dropped
  );

  modport slave (
    input  score_raw, game_active, finished_incrementing_score,
    output need_to_increment_score, pending_count, dropped
  );
endinterface

// File: rtl/debounce_sync.sv
// debounce_sync -- two-flop synchronizer, debounce counter and rising-edge
// detector for a mechanical contact; reusable for any button input.
//   clock, reset : system clock, asynchronous active-high reset
//   din          : raw asynchronous input
//   level        : debounced level
//   rise         : one-cycle pulse in the cycle level goes 0->1
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);
  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             rise_q,  rise_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // cnt_q holds how many consecutive cycles the synchronized input has
    // disagreed with level_q; the level flips on the Nth such cycle.
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
endmodule

// File: rtl/score_event_sync.sv
// score_event_sync -- turns the Arduino prize contact into counted score
// events and hands them one at a time to the processor wrapper.
//   clock, reset                : system clock, asynchronous active-high reset
//   score_raw                   : asynchronous prize contact
//   game_active                 : events are only accepted while high
//   finished_incrementing_score : acknowledge level from the wrapper
//   need_to_increment_score     : registered request for one point
//   pending_count               : accepted events not yet acknowledged
//   dropped                     : sticky overflow flag
//   accepted_count              : (SCORE_EVENT_COUNT_EN only) saturating
//                                 count of accepted events since reset
module score_event_sync
  import clawgame_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              score_raw,
  input  logic              game_active,
  input  logic              finished_incrementing_score,
  output logic              need_to_increment_score,
  output logic [PEND_W-1:0] pending_count,
  output logic              dropped
`ifdef SCORE_EVENT_COUNT_EN
  ,
  output logic [15:0]       accepted_count
`endif
);
  localparam logic [PEND_W-1:0] FULL = PEND_W'(MAX_PENDING);

  logic              score_level;
  logic              score_rise;
  logic              accept;
  logic              dec;
  hs_state_e         state_q, state_d;
  logic              req_q, req_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              drop_q, drop_d;

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clock (clock),
    .reset (reset),
    .din   (score_raw),
    .level (score_level),
    .rise  (score_rise)
  );

  assign accept = score_rise & game_active;
  // pend_q is never zero in REQ; the guard only protects against underflow.
  assign dec    = (state_q == REQ) && finished_incrementing_score && (pend_q != '0);

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; IDLE waits for game_active too, since pending is being
  // cleared in that case and must not launch a request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (game_active && pend_q != '0)  state_d = REQ;
      REQ:       if (finished_incrementing_score)  state_d = WAIT_DROP;
      WAIT_DROP: if (!finished_incrementing_score) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM output, decoded from the next state so the request is a flop
  always_comb begin
    req_d = (state_d == REQ);
  end

  always_comb begin
    pend_d = pend_q;
    drop_d = drop_q;
    if (state_q == IDLE && !game_active) begin
      pend_d = '0;
    end else begin
      unique case ({accept, dec})
        2'b10: begin
          if (pend_q == FULL) drop_d = 1'b1;
          else                pend_d = pend_q + 1'b1;
        end
        2'b01:   pend_d = pend_q - 1'b1;
        default: pend_d = pend_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_q  <= 1'b0;
      pend_q <= '0;
      drop_q <= 1'b0;
    end else begin
      req_q  <= req_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
    end
  end

  assign need_to_increment_score = req_q;
  assign pending_count           = pend_q;
  assign dropped                 = drop_q;

`ifdef SCORE_EVENT_COUNT_EN
  logic [15:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (accept && acc_q != 16'hFFFF) acc_d = acc_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign accepted_count = acc_q;
`endif
endmodule

// File: tb/tb_score_event_sync.sv
// tb_score_event_sync -- directed bench for score_event_sync with
// DEBOUNCE_CYCLES=4. Stimulus pushes the expected pending_count sequence into
// a queue; a monitor pops and compares whenever pending_count changes.
// Build with SCORE_EVENT_COUNT_EN defined to also check accepted_count.
module tb_score_event_sync;
  import clawgame_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  score_event_sync_if bus ();

  logic auto_ack = 1'b0;
  logic ack_man  = 1'b0;
  logic r1 = 1'b0, r2 = 1'b0;
  always @(posedge clk) begin
    r1 <= bus.need_to_increment_score;
    r2 <= r1;
  end
  // acknowledge follows the request two cycles late when auto_ack is set
  assign bus.finished_incrementing_score = auto_ack ? r2 : ack_man;

`ifdef SCORE_EVENT_COUNT_EN
  logic [15:0] accepted_count;
`endif

  score_event_sync #(.DEBOUNCE_CYCLES(4)) dut (
    .clock                       (clk),
    .reset                       (rst),
    .score_raw                   (bus.score_raw),
    .game_active                 (bus.game_active),
    .finished_incrementing_score (bus.finished_incrementing_score),
    .need_to_increment_score     (bus.need_to_increment_score),
    .pending_count               (bus.pending_count),
    .dropped                     (bus.dropped)
`ifdef SCORE_EVENT_COUNT_EN
    ,
    .accepted_count              (accepted_count)
`endif
  );

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int pulses = 0;
  logic prev_req = 1'b0;
  int   prev_pend = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (bus.need_to_increment_score && !prev_req) pulses++;
    prev_req = bus.need_to_increment_score;
    if (int'(bus.pending_count) != prev_pend) begin
      if (exp_q.size() == 0) chk("pend_unexpected_change", int'(bus.pending_count), prev_pend);
      else                   chk("pend_seq", int'(bus.pending_count), exp_q.pop_front());
      prev_pend = int'(bus.pending_count);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int hi, input int lo);
    bus.score_raw = 1'b1;
    tick(hi);
    bus.score_raw = 1'b0;
    tick(lo);
  endtask

  task automatic end_test(input string name, input int exp_pulses);
    chk({name, "_req_pulses"}, pulses, exp_pulses);
    chk({name, "_queue_drained"}, exp_q.size(), 0);
    pulses = 0;
  endtask

  initial begin
`ifdef SCORE_EVENT_COUNT_EN
    logic [15:0] acc_before;
`endif
    bus.score_raw   = 1'b0;
    bus.game_active = 1'b1;
    tick(3);
    chk("reset_req", int'(bus.need_to_increment_score), 0);
    chk("reset_pend", int'(bus.pending_count), 0);
    chk("reset_dropped", int'(bus.dropped), 0);
`ifdef SCORE_EVENT_COUNT_EN
    chk("reset_acc", int'(accepted_count), 0);
`endif
    rst = 1'b0;
    tick(2);

    // single clean press, acknowledge follows request
    auto_ack = 1'b1;
    exp_q.push_back(1); exp_q.push_back(0);
    press(10, 10);
    tick(20);
    chk("t1_dropped", int'(bus.dropped), 0);
    chk("t1_req_idle", int'(bus.need_to_increment_score), 0);
    end_test("t1", 1);

    // 3-cycle glitch is filtered out
    press(3, 12);
    chk("t2_pend", int'(bus.pending_count), 0);
    end_test("t2", 0);

    // overflow with acknowledge held low
    auto_ack = 1'b0; ack_man = 1'b0;
    for (int i = 1; i <= 7; i++) exp_q.push_back(i);
    for (int i = 0; i < 8; i++) press(6, 8);
    chk("t3_pend_sat", int'(bus.pending_count), 7);
    chk("t3_dropped", int'(bus.dropped), 1);
    chk("t3_req_held", int'(bus.need_to_increment_score), 1);
    end_test("t3", 1);
`ifdef SCORE_EVENT_COUNT_EN
    chk("t3_acc", int'(accepted_count), 9);
`endif
    exp_q.push_back(0);
    rst = 1'b1; tick(2); rst = 1'b0; tick(2);
    chk("t3_dropped_cleared", int'(bus.dropped), 0);
    pulses = 0;

    // event accepted in the same cycle the acknowledge is sampled
    exp_q.push_back(1); exp_q.push_back(2);
    press(6, 8);
    press(6, 8);
    chk("t4_pend_pre", int'(bus.pending_count), 2);
    chk("t4_req_pre", int'(bus.need_to_increment_score), 1);
    bus.score_raw = 1'b1;
    tick(6);          // rise is now presented, accepted at the next edge
    ack_man = 1'b1;
    tick(1);
    chk("t4_pend_same", int'(bus.pending_count), 2);
    chk("t4_req_wait_drop", int'(bus.need_to_increment_score), 0);
    bus.score_raw = 1'b0;
    ack_man = 1'b0;
    exp_q.push_back(1); exp_q.push_back(0);
    auto_ack = 1'b1;
    tick(40);
    end_test("t4", 3);

    // press while game inactive is discarded
`ifdef SCORE_EVENT_COUNT_EN
    acc_before = accepted_count;
`endif
    bus.game_active = 1'b0;
    press(8, 10);
    chk("t5_pend", int'(bus.pending_count), 0);
    chk("t5_req", int'(bus.need_to_increment_score), 0);
`ifdef SCORE_EVENT_COUNT_EN
    chk("t5_acc_unchanged", int'(accepted_count), int'(acc_before));
`endif
    end_test("t5", 0);
    bus.game_active = 1'b1;

    // reset in the middle of a request
    auto_ack = 1'b0; ack_man = 1'b0;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    for (int i = 0; i < 3; i++) press(6, 8);
    chk("t6_req_pre", int'(bus.need_to_increment_score), 1);
    chk("t6_pend_pre", int'(bus.pending_count), 3);
    exp_q.push_back(0);
    #2 rst = 1'b1;
    #1;
    chk("t6_req_async", int'(bus.need_to_increment_score), 0);
    chk("t6_pend_async", int'(bus.pending_count), 0);
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("t6_req_after", int'(bus.need_to_increment_score), 0);
    end_test("t6", 1);
    auto_ack = 1'b1;
    exp_q.push_back(1); exp_q.push_back(0);
    press(6, 8);
    tick(20);
    end_test("t6_post", 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
